sort_result_reader: RTL and testbench
=====================================

// Module: sort_result_reader
// PURPOSE
//  Drain side of the register sorting network. Waits for the sorter's sticky done, captures
//  the parallel sorted frame (data + index), then streams it out one element per beat
//  over a valid/ready interface. After the last beat it pulses the sorter's synchronous
//  clear so the next frame can be sorted. Sits between comparison-network output and consumer.
// PARAMETERS
//  SIZE           4   elements per frame; power of 2, >= 2 (matches sorter SIZE)
//  OUT_COUNT      4   beats emitted per frame (top-K); 1 <= OUT_COUNT <= SIZE
//  READ_FROM_TOP  0   0: emit element [0] first, ascending position; 1: [SIZE-1] first, descending
//  NETWORK_WIDTH, INDEX_WIDTH: global widths from network_params.svh (not overridable here)
// PORTS
//  clk         in   1                    clock; all state on posedge
//  reset_n     in   1                    asynchronous, active-low reset
//  sort_done   in   1                    sorter done; level, sticky until sorter cleared
//  sort_data   in   SIZE*NETWORK_WIDTH   sorted data frame, [SIZE-1:0][NETWORK_WIDTH-1:0]
//  sort_index  in   SIZE*INDEX_WIDTH     sorted index frame, [SIZE-1:0][INDEX_WIDTH-1:0]
//  sort_reset  out  1                    sync active-high clear to sorter, 1-cycle pulse
//  out_valid   out  1                    beat valid
//  out_ready   in   1                    consumer accepts beat
//  out_data    out  NETWORK_WIDTH        beat data
//  out_index   out  INDEX_WIDTH          beat original index
//  out_rank    out  $clog2(SIZE)         beat ordinal in frame, 0..OUT_COUNT-1
//  out_last    out  1                    final beat of frame (rank == OUT_COUNT-1)
//  busy        out  1                    state != IDLE
//  frame_count out  16                   frames fully drained; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; every output 0; frame buffer/counters cleared.
//  States: IDLE -> STREAM -> FLUSH -> WAIT_CLR -> IDLE.
//  IDLE: on posedge with sort_done=1, latch sort_data/sort_index into frame buffer, load
//   out_data/out_index with first element, out_rank=0, out_valid=1, go STREAM. Latency:
//   out_valid high one edge after sort_done first sampled high. sort_done=0: stay IDLE.
//  STREAM: beat transfers on posedge with out_valid & out_ready. Non-final transfer:
//   rank++, next element (position rank or SIZE-1-rank per READ_FROM_TOP) loaded same edge,
//   out_valid stays 1 -> full throughput, one beat/cycle with out_ready held high.
//   Stall (out_ready=0): all out_* held stable, no skip or duplicate.
//   Final transfer (out_last=1): out_valid/out_last -> 0, frame_count++, go FLUSH.
//   Inputs ignored in STREAM: sort_data/sort_index changes and sort_done drops have no effect.
//  FLUSH: sort_reset=1 for exactly this one cycle; go WAIT_CLR.
//  WAIT_CLR: stay until sort_done sampled 0, then IDLE (prevents re-capturing stale sticky done).
//  OUT_COUNT=1: first beat carries out_last=1. OUT_COUNT<SIZE: remaining elements discarded.
//  out_rank/out_last are 0 whenever out_valid=0.
//  Reset mid-frame: frame dropped immediately, no residual beats after release, no sort_reset.
//  Min frame period with out_ready=1: 1 + OUT_COUNT + 1 + clear latency cycles.
// TESTING
//  T1 SIZE=4,OUT_COUNT=4,TOP=0; data[3:0]={40,30,20,10}, index={3,2,1,0}; sort_done=1,
//     out_ready=1 -> beats 10,20,30,40 on 4 consecutive cycles, rank 0..3, last on 40,
//     sort_reset 1-cycle pulse next cycle, frame_count=1.
//  T2 Same frame, out_ready pattern 1,0,0,1,0,1,1 -> beats 10,20,30,40 in order, out_* stable
//     during every stall, exactly 4 transfers.
//  T3 READ_FROM_TOP=1, OUT_COUNT=2 -> beats 40 (rank0), 30 (rank1, last); 20/10 never emitted.
//  T4 Hold sort_done=1 after sort_reset pulse for 10 cycles -> stay WAIT_CLR, busy=1, no new
//     beats; drop sort_done -> IDLE; raise again with new frame -> new frame streams, count=2.
//  T5 reset_n=0 after 2 beats accepted -> all outputs 0 asynchronously (before next edge);
//     release with sort_done=0 -> idle, frame_count=0, no beats.
//  T6 Change sort_data to all 0xFF mid-STREAM -> remaining beats still 30,40 from captured frame.

Source files
------------

// File: rtl/sort_result_reader.sv
// Drain side of the register sorting network: captures a sorted frame once the sorter reports
// done, streams the top OUT_COUNT elements over valid/ready, then pulses the sorter clear.
module sort_result_reader #(
    parameter int unsigned SIZE          = 4,
    parameter int unsigned OUT_COUNT     = 4,
    parameter bit          READ_FROM_TOP = 1'b0,
    localparam int unsigned NetworkWidth = 16,
    localparam int unsigned IndexWidth   = 8,
    localparam int unsigned RankWidth    = $clog2(SIZE)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   sort_done_i,
    input  logic [SIZE-1:0][NetworkWidth-1:0]      sort_data_i,
    input  logic [SIZE-1:0][IndexWidth-1:0]        sort_index_i,
    output logic                                   sort_reset_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [NetworkWidth-1:0]                out_data_o,
    output logic [IndexWidth-1:0]                  out_index_o,
    output logic [RankWidth-1:0]                   out_rank_o,
    output logic                                   out_last_o,
    output logic                                   busy_o,
    output logic [15:0]                            frame_count_o
);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StWaitClr
    } state_e;

    state_e                            state_q;
    logic [SIZE-1:0][NetworkWidth-1:0] data_q;
    logic [SIZE-1:0][IndexWidth-1:0]   index_q;
    logic [RankWidth-1:0]              rank_q;
    logic                              valid_q;
    logic                              last_q;
    logic                              sort_reset_q;
    logic [NetworkWidth-1:0]           out_data_q;
    logic [IndexWidth-1:0]             out_index_q;
    logic [15:0]                       frame_count_q;

    logic [RankWidth-1:0] next_rank;
    logic [RankWidth-1:0] first_pos;
    logic [RankWidth-1:0] next_pos;
    logic                 next_is_last;
    logic                 transfer;

    // Rank is the emission ordinal; position maps it onto the frame buffer per read direction.
    assign next_rank    = rank_q + RankWidth'(1);
    assign first_pos    = READ_FROM_TOP ? RankWidth'(SIZE - 1) : '0;
    assign next_pos     = READ_FROM_TOP ? RankWidth'(SIZE - 1) - next_rank : next_rank;
    assign next_is_last = (next_rank == RankWidth'(OUT_COUNT - 1));
    assign transfer     = valid_q & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            data_q        <= '0;
            index_q       <= '0;
            rank_q        <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            sort_reset_q  <= 1'b0;
            out_data_q    <= '0;
            out_index_q   <= '0;
            frame_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sort_done_i) begin
                        data_q      <= sort_data_i;
                        index_q     <= sort_index_i;
                        out_data_q  <= sort_data_i[first_pos];
                        out_index_q <= sort_index_i[first_pos];
                        rank_q      <= '0;
                        valid_q     <= 1'b1;
                        last_q      <= (OUT_COUNT == 1);
                        state_q     <= StStream;
                    end
                end
                StStream: begin
                    if (transfer) begin
                        if (last_q) begin
                            valid_q       <= 1'b0;
                            last_q        <= 1'b0;
                            rank_q        <= '0;
                            frame_count_q <= frame_count_q + 16'd1;
                            sort_reset_q  <= 1'b1;
                            state_q       <= StFlush;
                        end else begin
                            rank_q      <= next_rank;
                            out_data_q  <= data_q[next_pos];
                            out_index_q <= index_q[next_pos];
                            last_q      <= next_is_last;
                        end
                    end
                end
                StFlush: begin
                    sort_reset_q <= 1'b0;
                    state_q      <= StWaitClr;
                end
                StWaitClr: begin
                    // Sorter done is sticky; wait for it to fall so the old frame is not re-read.
                    if (!sort_done_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sort_reset_o  = sort_reset_q;
    assign out_valid_o   = valid_q;
    assign out_data_o    = out_data_q;
    assign out_index_o   = out_index_q;
    assign out_rank_o    = rank_q;
    assign out_last_o    = last_q;
    assign busy_o        = (state_q != StIdle);
    assign frame_count_o = frame_count_q;

`ifndef SYNTHESIS
    a_idle_sideband_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !out_valid_o |-> (out_rank_o == '0) && !out_last_o);
    a_clear_not_streaming : assert property (@(posedge clk_i) disable iff (!rst_ni)
        sort_reset_o |-> !out_valid_o);
    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i) |=> out_valid_o && $stable(out_data_o)
                                          && $stable(out_index_o) && $stable(out_rank_o));
`endif

endmodule

// File: tb/tb_sort_result_reader.sv
// Bench for sort_result_reader: two instances (bottom-first full frame, top-first top-2) share
// stimulus and are checked every cycle against a queue-level model plus literal expectations.
module tb_sort_result_reader;

    localparam int unsigned Size = 4;
    localparam int unsigned Nw   = 16;
    localparam int unsigned Iw   = 8;
    localparam int unsigned Rw   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done = 1'b0;
    logic ready = 1'b0;
    logic [Size-1:0][Nw-1:0] sdata = '0;
    logic [Size-1:0][Iw-1:0] sidx = '0;

    logic          sreset [2];
    logic          valid  [2];
    logic [Nw-1:0] odata  [2];
    logic [Iw-1:0] oindex [2];
    logic [Rw-1:0] orank  [2];
    logic          olast  [2];
    logic          obusy  [2];
    logic [15:0]   ofc    [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sort_result_reader #(.SIZE(4), .OUT_COUNT(4), .READ_FROM_TOP(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .sort_done_i(done), .sort_data_i(sdata),
        .sort_index_i(sidx), .sort_reset_o(sreset[0]), .out_valid_o(valid[0]),
        .out_ready_i(ready), .out_data_o(odata[0]), .out_index_o(oindex[0]),
        .out_rank_o(orank[0]), .out_last_o(olast[0]), .busy_o(obusy[0]),
        .frame_count_o(ofc[0])
    );

    sort_result_reader #(.SIZE(4), .OUT_COUNT(2), .READ_FROM_TOP(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .sort_done_i(done), .sort_data_i(sdata),
        .sort_index_i(sidx), .sort_reset_o(sreset[1]), .out_valid_o(valid[1]),
        .out_ready_i(ready), .out_data_o(odata[1]), .out_index_o(oindex[1]),
        .out_rank_o(orank[1]), .out_last_o(olast[1]), .busy_o(obusy[1]),
        .frame_count_o(ofc[1])
    );

    // Model: 0 idle, 1 beats pending, 2 clear pulse, 3 waiting for done to fall.
    int            m_cnt [2] = '{4, 2};
    bit            m_top [2] = '{1'b0, 1'b1};
    int            phase [2];
    int            m_sent [2];
    logic [15:0]   m_fc [2];
    logic [Nw-1:0] md [2][Size];
    logic [Iw-1:0] mi [2][Size];

    logic [Nw-1:0] acc_d [2][$];
    int            acc_r [2][$];

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int pos;
        case (phase[k])
            0: if (done) begin
                for (int r = 0; r < m_cnt[k]; r++) begin
                    pos = m_top[k] ? Size - 1 - r : r;
                    md[k][r] = sdata[pos];
                    mi[k][r] = sidx[pos];
                end
                m_sent[k] = 0;
                phase[k] = 1;
            end
            1: if (ready) begin
                m_sent[k]++;
                if (m_sent[k] == m_cnt[k]) begin
                    m_fc[k] = m_fc[k] + 16'd1;
                    phase[k] = 2;
                end
            end
            2: phase[k] = 3;
            default: if (!done) phase[k] = 0;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                phase[k] = 0;
                m_sent[k] = 0;
                m_fc[k] = '0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic ev;
            ev = (phase[k] == 1);
            chk("valid", k, valid[k], ev);
            chk("rank", k, orank[k], ev ? m_sent[k] : 0);
            chk("last", k, olast[k], ev && (m_sent[k] == m_cnt[k] - 1));
            if (ev) begin
                chk("data", k, odata[k], md[k][m_sent[k]]);
                chk("index", k, oindex[k], mi[k][m_sent[k]]);
            end
            chk("sort_reset", k, sreset[k], phase[k] == 2);
            chk("busy", k, obusy[k], phase[k] != 0);
            chk("frame_count", k, ofc[k], m_fc[k]);
            if (valid[k] && ready && rst_n) begin
                acc_d[k].push_back(odata[k]);
                acc_r[k].push_back(int'(orank[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [Nw-1:0] d3, d2, d1, d0);
        sdata = {d3, d2, d1, d0};
        sidx = {8'd3, 8'd2, 8'd1, 8'd0};
    endtask

    task automatic clear_acc();
        for (int k = 0; k < 2; k++) begin
            acc_d[k].delete();
            acc_r[k].delete();
        end
    endtask

    // Wait (bounded) for both readers to finish streaming, hold done 10 cycles, then drop it.
    task automatic drain();
        int i;
        i = 0;
        while (i < 200 && !((phase[0] == 0 || phase[0] == 3) && (phase[1] == 0 || phase[1] == 3)))
        begin
            tick();
            i++;
        end
        chk("drain_timeout", 0, i < 200, 1);
        repeat (10) tick();
        done = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_beats(input string name, input int k, input logic [Nw-1:0] e0, e1, e2,
                             e3, input int n);
        logic [Nw-1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        chk({name, "_count"}, k, acc_d[k].size(), n);
        for (int j = 0; j < n && j < acc_d[k].size(); j++) begin
            chk({name, "_beat"}, k, acc_d[k][j], exp[j]);
            chk({name, "_rank"}, k, acc_r[k][j], j);
        end
    endtask

    initial begin
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset_valid", k, valid[k], 0);
            chk("reset_busy", k, obusy[k], 0);
            chk("reset_fc", k, ofc[k], 0);
            chk("reset_sort_reset", k, sreset[k], 0);
        end
        rst_n = 1'b1;
        tick();

        // Full-throughput frame; also holds done after the clear pulse.
        clear_acc();
        set_frame(16'd40, 16'd30, 16'd20, 16'd10);
        ready = 1'b1;
        done = 1'b1;
        tick();
        chk("first_beat_latency", 0, valid[0], 1);
        chk("first_beat_data", 0, odata[0], 16'd10);
        chk("first_beat_data", 1, odata[1], 16'd40);
        drain();
        chk_beats("t1", 0, 16'd10, 16'd20, 16'd30, 16'd40, 4);
        chk_beats("t3", 1, 16'd40, 16'd30, 16'd0, 16'd0, 2);
        chk("t1_fc", 0, ofc[0], 1);
        chk("t1_idle", 0, obusy[0], 0);

        // Stalled frame.
        clear_acc();
        done = 1'b1;
        ready = 1'b0;
        tick();
        foreach (pat[j]) begin
            ready = pat[j];
            tick();
        end
        ready = 1'b1;
        drain();
        chk_beats("t2", 0, 16'd10, 16'd20, 16'd30, 16'd40, 4);
        chk("t2_fc", 0, ofc[0], 2);
        chk("t2_fc", 1, ofc[1], 2);

        // Input corruption and done drop mid-stream must not disturb the captured frame.
        clear_acc();
        done = 1'b1;
        tick();
        tick();
        tick();
        sdata = {Size{16'h00FF}};
        sidx = {Size{8'hFF}};
        done = 1'b0;
        drain();
        chk_beats("t6", 0, 16'd10, 16'd20, 16'd30, 16'd40, 4);
        chk("t6_fc", 0, ofc[0], 3);

        // Random traffic, all checked by the model.
        for (int c = 0; c < 1500; c++) begin
            done = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                for (int p = 0; p < Size; p++) begin
                    sdata[p] = Nw'($urandom);
                    sidx[p] = Iw'($urandom);
                end
            end
            tick();
        end
        done = 1'b0;
        ready = 1'b1;
        repeat (20) tick();

        // Asynchronous reset after two accepted beats.
        set_frame(16'd40, 16'd30, 16'd20, 16'd10);
        done = 1'b1;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        done = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_valid", k, valid[k], 0);
            chk("async_data", k, odata[k], 0);
            chk("async_rank", k, orank[k], 0);
            chk("async_last", k, olast[k], 0);
            chk("async_sort_reset", k, sreset[k], 0);
            chk("async_busy", k, obusy[k], 0);
            chk("async_fc", k, ofc[k], 0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < 2; k++) begin
            chk("post_reset_valid", k, valid[k], 0);
            chk("post_reset_fc", k, ofc[k], 0);
            chk("post_reset_busy", k, obusy[k], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
